// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle between a requester and apb_slave_mem
// Signals:
//   PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[31:0]  requester -> completer
//   PRDATA[31:0], PREADY, PSLVERR                     completer -> requester
// Clock and reset are plain ports on the modules, not part of this bundle.
interface apb_slave_mem_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer backed by a word-addressed register memory
// Ports:
//   PCLK    clock, rising edge
//   PRESET  synchronous active-high reset; clears FSM, outputs and memory
//   bus     apb_slave_mem_if.slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//           PRDATA/PREADY/PSLVERR out, all outputs registered)
// Parameters:
//   DEPTH        number of 32-bit words, power of two, 2..1024
//   WAIT_STATES  ACCESS cycles with PREADY=0 before completion, 0..15
// Build option:
//   APB_SLVERR_EN  defined: index >= DEPTH completes with PSLVERR=1, writes
//                  dropped, reads return 0. Undefined: index wraps modulo DEPTH.
module apb_slave_mem #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_slave_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [29:0] idx_q, idx_next;
    logic        write_q, write_next;
    logic [31:0] wdata_q, wdata_next;
    logic        ready_q, ready_next;
    logic [31:0] rdata_q, rdata_next;
    logic        mem_we;
    logic        complete;

    logic [31:0] mem [DEPTH];

    // In IDLE the completion decision (WAIT_STATES=0) is made on the SETUP
    // edge itself, before the request has been latched, so look straight at
    // the bus there and at the latched copy once in ACCESS.
    logic [29:0] cur_idx;
    logic        cur_write;
    logic [AW-1:0] slot;
    logic        oor;

    assign cur_idx   = (state == IDLE) ? bus.PADDR[31:2] : idx_q;
    assign cur_write = (state == IDLE) ? bus.PWRITE : write_q;
    assign slot      = cur_idx[AW-1:0];

`ifdef APB_SLVERR_EN
    logic err_q, err_next;
    assign oor = (cur_idx >= 30'(DEPTH));
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.PADDR[1:0]};
`else
    assign oor = 1'b0;
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.PADDR[1:0], cur_idx[29:AW]};
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx_q;
        write_next = write_q;
        wdata_next = wdata_q;
        ready_next = 1'b0;
        rdata_next = '0;
        mem_we     = 1'b0;
        complete   = 1'b0;
`ifdef APB_SLVERR_EN
        err_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // PSEL with PENABLE already high means no SETUP was seen: ignore.
                if (bus.PSEL && !bus.PENABLE) begin
                    state_next = ACCESS;
                    idx_next   = bus.PADDR[31:2];
                    write_next = bus.PWRITE;
                    wdata_next = bus.PWDATA;
                    cnt_next   = 4'(WAIT_STATES);
                    complete   = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (ready_q) begin
                    state_next = IDLE;
                    mem_we     = write_q && bus.PENABLE && !oor;
                end else if (cnt > 4'd1) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    // Last wait cycle: counter hits zero and PREADY rises together.
                    cnt_next = '0;
                    complete = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (complete) begin
            ready_next = 1'b1;
            if (!cur_write && !oor)
                rdata_next = mem[slot];
`ifdef APB_SLVERR_EN
            err_next = oor;
`endif
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
`ifdef APB_SLVERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx_q   <= idx_next;
            write_q <= write_next;
            wdata_q <= wdata_next;
            ready_q <= ready_next;
            rdata_q <= rdata_next;
`ifdef APB_SLVERR_EN
            err_q   <= err_next;
`endif
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (mem_we) begin
            mem[slot] <= wdata_q;
        end
    end

    assign bus.PREADY  = ready_q;
    assign bus.PRDATA  = rdata_q;
`ifdef APB_SLVERR_EN
    assign bus.PSLVERR = err_q;
`else
    assign bus.PSLVERR = 1'b0;
`endif
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem (three wait-state variants)
module tb_apb_slave_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    int          sel;

    apb_slave_mem_if b0();
    apb_slave_mem_if b1();
    apb_slave_mem_if b2();

    // Only the selected instance sees PSEL; the rest of the bus is shared.
    assign b0.PSEL = psel && (sel == 0);
    assign b1.PSEL = psel && (sel == 1);
    assign b2.PSEL = psel && (sel == 2);
    assign b0.PENABLE = penable; assign b1.PENABLE = penable; assign b2.PENABLE = penable;
    assign b0.PWRITE  = pwrite;  assign b1.PWRITE  = pwrite;  assign b2.PWRITE  = pwrite;
    assign b0.PADDR   = paddr;   assign b1.PADDR   = paddr;   assign b2.PADDR   = paddr;
    assign b0.PWDATA  = pwdata;  assign b1.PWDATA  = pwdata;  assign b2.PWDATA  = pwdata;

    apb_slave_mem #(.DEPTH(64), .WAIT_STATES(0)) d0 (.PCLK(clk), .PRESET(rst), .bus(b0));
    apb_slave_mem #(.DEPTH(64), .WAIT_STATES(3)) d1 (.PCLK(clk), .PRESET(rst), .bus(b1));
    apb_slave_mem #(.DEPTH(64), .WAIT_STATES(2)) d2 (.PCLK(clk), .PRESET(rst), .bus(b2));

    logic [2:0]  rdy, errv;
    logic [31:0] rd [3];
    assign rdy[0] = b0.PREADY;  assign rdy[1] = b1.PREADY;  assign rdy[2] = b2.PREADY;
    assign errv[0] = b0.PSLVERR; assign errv[1] = b1.PSLVERR; assign errv[2] = b2.PSLVERR;
    assign rd[0] = b0.PRDATA;   assign rd[1] = b1.PRDATA;   assign rd[2] = b2.PRDATA;

    int ws [3] = '{0, 3, 2};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one plain word array per instance.
    logic [31:0] model_mem [3][64];

    function automatic bit model_oor(input logic [31:0] a);
        return (a >> 2) >= 64;
    endfunction

    function automatic int model_slot(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic bit model_err(input logic [31:0] a);
`ifdef APB_SLVERR_EN
        return model_oor(a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input int s, input logic [31:0] a);
        if (model_err(a)) return 32'h0;
        return model_mem[s][model_slot(a)];
    endfunction

    task automatic model_write(input int s, input logic [31:0] a, input logic [31:0] d);
        if (!model_err(a)) model_mem[s][model_slot(a)] = d;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 64; i++)
                model_mem[s][i] = 32'h0;
    endtask

    // One APB transfer starting at a negedge; returns at the negedge after completion.
    task automatic xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output bit err, output int waits,
                        output bit clean);
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        clean = 1'b1;
        while (!rdy[s] && waits < 40) begin
            if (rd[s] !== 32'h0 || errv[s] !== 1'b0) clean = 1'b0;
            waits++;
            @(negedge clk);
        end
        rdata = rd[s];
        err = errv[s];
        @(negedge clk);
        if (rdy[s] !== 1'b0 || rd[s] !== 32'h0 || errv[s] !== 1'b0) clean = 1'b0;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run_xfer(input string name, input int s, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rdata;
        bit err, clean;
        int waits;
        xfer(s, wr, a, d, rdata, err, waits, clean);
        check({name, "_waits"}, waits, ws[s]);
        check({name, "_quiet"}, {31'h0, clean}, 32'h1);
        check({name, "_err"}, {31'h0, err}, {31'h0, exp_err});
        check({name, "_rdata"}, rdata, wr ? 32'h0 : exp_rd);
        if (wr) model_write(s, a, d);
    endtask

    typedef struct {
        int          s;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        logic [31:0] oor_val;
        bit saw_ready;
`ifdef APB_SLVERR_EN
        m = 1'b1;
`else
        m = 1'b0;
`endif
        oor_val = m ? 32'h0 : 32'h5555_5555;

        vecs.push_back(vec_t'{0, 1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0});
        vecs.push_back(vec_t'{0, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back(vec_t'{0, 1'b1, 32'h100, 32'h5555_5555, 32'h0,         m});
        vecs.push_back(vec_t'{0, 1'b0, 32'h0,   32'h0,         oor_val,       1'b0});
        vecs.push_back(vec_t'{0, 1'b0, 32'h100, 32'h0,         oor_val,       m});
        vecs.push_back(vec_t'{0, 1'b1, 32'hFC,  32'h0000_0001, 32'h0,         1'b0});
        vecs.push_back(vec_t'{0, 1'b0, 32'hFC,  32'h0,         32'h0000_0001, 1'b0});
        vecs.push_back(vec_t'{0, 1'b1, 32'h13,  32'hA5A5_0000, 32'h0,         1'b0});
        vecs.push_back(vec_t'{0, 1'b0, 32'h10,  32'h0,         32'hA5A5_0000, 1'b0});
        vecs.push_back(vec_t'{1, 1'b1, 32'h8,   32'h1234_5678, 32'h0,         1'b0});
        vecs.push_back(vec_t'{1, 1'b0, 32'h8,   32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back(vec_t'{1, 1'b0, 32'h10,  32'h0,         32'h0,         1'b0});
        vecs.push_back(vec_t'{2, 1'b1, 32'h4,   32'h0BAD_F00D, 32'h0,         1'b0});
        vecs.push_back(vec_t'{2, 1'b0, 32'h4,   32'h0,         32'h0BAD_F00D, 1'b0});

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; sel = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {29'h0, rdy}, 32'h0);
        check("reset_err", {29'h0, errv}, 32'h0);
        check("reset_rdata0", rd[0], 32'h0);
        check("reset_rdata1", rd[1], 32'h0);
        rst = 1'b0;

        run_xfer("reset_read", 0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++)
            run_xfer($sformatf("vec%0d", i), vecs[i].s, vecs[i].wr, vecs[i].addr,
                     vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);

        // Abort: drop PSEL during the first wait cycle of a write on the 2-wait instance.
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hAAAA_AAAA;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdy[2]) saw_ready = 1'b1;
        end
        check("abort_no_ready", {31'h0, saw_ready}, 32'h0);
        run_xfer("abort_read", 2, 1'b0, 32'h4, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Reset during the ACCESS cycle of a write on the 0-wait instance.
        run_xfer("pre_rst_wr", 0, 1'b1, 32'hC, 32'h1111_2222, 32'h0, 1'b0);
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h7777_7777;
        @(negedge clk);
        penable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {31'h0, rdy[0]}, 32'h0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_clear();
        run_xfer("rst_mid_read", 0, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0);
        run_xfer("rst_mid_read1", 1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

        // Random traffic against the model, with occasional idle gaps.
        for (int n = 0; n < 200; n++) begin
            int s;
            bit wr;
            logic [31:0] a, d;
            s  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 'h13F));
            d  = $urandom;
            run_xfer($sformatf("rnd%0d", n), s, wr, a, d, model_read(s, a), model_err(a));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
